// File: rtl/aes_sbox_sched_pkg.sv
// Shared types and constants for the time-shared AES S-box scheduler.
package aes_sbox_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    DONE = 2'd2
  } sched_state_e;

  typedef enum logic {
    CIPH_FWD = 1'b0,
    CIPH_INV = 1'b1
  } ciph_op_e;

  typedef enum logic {
    OWN_ST  = 1'b0,
    OWN_KEY = 1'b1
  } owner_e;

  localparam int unsigned ST_LEN  = 16;
  localparam int unsigned KEY_LEN = 4;
  localparam int unsigned CNT_W   = 5;

endpackage

// File: rtl/aes_sbox_canright.sv
// Combinational AES S-box, forward and inverse, built from GF(2^8)
// inversion plus the affine map and its inverse.
module aes_sbox_canright
  import aes_sbox_sched_pkg::*;
(
  input  ciph_op_e   op_i,
  input  logic [7:0] data_i,
  output logic [7:0] data_o
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = '0;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse, and maps 0 to 0 as AES requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] t;
    r = 8'h01;
    t = x;
    for (int i = 1; i < 8; i++) begin
      t = gf_mul(t, t);
      r = gf_mul(r, t);
    end
    return r;
  endfunction

  function automatic logic [7:0] affine_fwd(input logic [7:0] x);
    return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]} ^
           {x[3:0], x[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] affine_inv(input logic [7:0] x);
    return {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
  endfunction

  // Forward: invert then affine; inverse: undo affine then invert.
  always_comb begin
    if (op_i == CIPH_INV) data_o = gf_inv(affine_inv(data_i));
    else                  data_o = affine_fwd(gf_inv(data_i));
  end

endmodule

// File: rtl/aes_sbox_sched.sv
// Time-shares one S-box between a 16-byte state requester and a 4-byte
// key-schedule requester, one byte per cycle.
// Optional macro AES_SBOX_SCHED_PIPE_EN adds a register after the S-box.
module aes_sbox_sched
  import aes_sbox_sched_pkg::*;
#(
  parameter logic RR_EN = 1'b1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         st_req_i,
  input  logic         st_op_i,
  input  logic [127:0] st_data_i,
  output logic         st_gnt_o,
  output logic         st_valid_o,
  input  logic         st_ready_i,
  output logic [127:0] st_data_o,
  input  logic         key_req_i,
  input  logic [31:0]  key_data_i,
  output logic         key_gnt_o,
  output logic         key_valid_o,
  input  logic         key_ready_i,
  output logic [31:0]  key_data_o,
  output logic         busy_o
);

  sched_state_e     state_q, state_nxt;
  logic [127:0]     data_q;
  ciph_op_e         op_q;
  owner_e           own_q;
  owner_e           last_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] len;
  logic [3:0]       last_idx;

  logic             vld_p0;
  logic [6:0]       rd_base_p0;
  logic [7:0]       sb_in_p0;
  logic [7:0]       sb_out_p0;

  logic             wr_en;
  logic [3:0]       wr_idx;
  logic [7:0]       wr_data;
  logic             last_wr;

  assign len      = (own_q == OWN_KEY) ? CNT_W'(KEY_LEN) : CNT_W'(ST_LEN);
  assign last_idx = (own_q == OWN_KEY) ? 4'(KEY_LEN - 1) : 4'(ST_LEN - 1);

  // Stage 0: select byte cnt of the job buffer and feed the shared S-box
  assign vld_p0     = (state_q == SUB) && (cnt_q < len);
  assign rd_base_p0 = {cnt_q[3:0], 3'b000};
  assign sb_in_p0   = data_q[rd_base_p0 +: 8];

  aes_sbox_canright u_sbox (
    .op_i   (op_q),
    .data_i (sb_in_p0),
    .data_o (sb_out_p0)
  );

`ifdef AES_SBOX_SCHED_PIPE_EN
  logic       vld_p1;
  logic [3:0] idx_p1;
  logic [7:0] sb_p1;

  // Stage 1: registered S-box result, written back one cycle after the feed
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_p1 <= 1'b0;
      idx_p1 <= '0;
      sb_p1  <= '0;
    end else begin
      vld_p1 <= vld_p0;
      idx_p1 <= cnt_q[3:0];
      sb_p1  <= sb_out_p0;
    end
  end

  assign wr_en   = vld_p1;
  assign wr_idx  = idx_p1;
  assign wr_data = sb_p1;
  assign last_wr = vld_p1 && (idx_p1 == last_idx);
`else
  assign wr_en   = vld_p0;
  assign wr_idx  = cnt_q[3:0];
  assign wr_data = sb_out_p0;
  assign last_wr = vld_p0 && (cnt_q[3:0] == last_idx);
`endif

  // State register of the scheduler FSM
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_nxt;
  end

  // Arbitration and next state; grants only in IDLE, key preferred on a tie
  // unless round-robin says key was served last
  always_comb begin
    state_nxt = state_q;
    st_gnt_o  = 1'b0;
    key_gnt_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rst_i) begin
          if (key_req_i && st_req_i) begin
            if (RR_EN && (last_q == OWN_KEY)) st_gnt_o  = 1'b1;
            else                              key_gnt_o = 1'b1;
          end else if (key_req_i) begin
            key_gnt_o = 1'b1;
          end else if (st_req_i) begin
            st_gnt_o = 1'b1;
          end
        end
        if (st_gnt_o || key_gnt_o) state_nxt = SUB;
      end
      SUB: begin
        if (last_wr) state_nxt = DONE;
      end
      DONE: begin
        if (((own_q == OWN_ST) && st_ready_i) || ((own_q == OWN_KEY) && key_ready_i))
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Job capture on accept, then in-place byte substitution
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q <= '0;
      op_q   <= CIPH_FWD;
      own_q  <= OWN_ST;
      last_q <= OWN_ST;
      cnt_q  <= '0;
    end else if (st_gnt_o) begin
      data_q <= st_data_i;
      op_q   <= ciph_op_e'(st_op_i);
      own_q  <= OWN_ST;
      last_q <= OWN_ST;
      cnt_q  <= '0;
    end else if (key_gnt_o) begin
      data_q <= {96'b0, key_data_i};
      op_q   <= CIPH_FWD;
      own_q  <= OWN_KEY;
      last_q <= OWN_KEY;
      cnt_q  <= '0;
    end else begin
      if (vld_p0) cnt_q <= cnt_q + CNT_W'(1);
      if (wr_en)  data_q[{wr_idx, 3'b000} +: 8] <= wr_data;
    end
  end

  assign st_valid_o  = (state_q == DONE) && (own_q == OWN_ST);
  assign key_valid_o = (state_q == DONE) && (own_q == OWN_KEY);
  assign st_data_o   = st_valid_o  ? data_q        : '0;
  assign key_data_o  = key_valid_o ? data_q[31:0]  : '0;
  assign busy_o      = (state_q != IDLE);

endmodule
